// File: rtl/serial_subtractor_if.sv
// Start/result bundle for the bit-serial subtractor: operands in, status and registered result out.
// Master drives the request side; slave (the subtractor) drives status and results.
interface serial_subtractor_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] minuend;
  logic [WIDTH-1:0] subtrahend;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] difference;
  logic             borrow;
  logic             zero;

  modport master (
    output start,
    output minuend,
    output subtrahend,
    input  busy,
    input  done,
    input  difference,
    input  borrow,
    input  zero
  );

  modport slave (
    input  start,
    input  minuend,
    input  subtrahend,
    output busy,
    output done,
    output difference,
    output borrow,
    output zero
  );
endinterface

// File: rtl/serial_subtractor.sv
// Bit-serial minuend - subtrahend, LSB first with one borrow flop; result after WIDTH RUN cycles.
// start is taken only in IDLE/DONE and silently dropped while busy; results hold until the next commit.
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  serial_subtractor_if.slave  sub
);

  localparam int CW = $clog2(WIDTH + 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  logic [1:0]       state;
  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic [WIDTH-1:0] d_sr;
  logic [WIDTH-1:0] d_next;
  logic [CW-1:0]    cnt;
  logic             br;
  logic             br_next;
  logic             bit_a;
  logic             bit_b;
  logic             bit_d;

  logic [WIDTH-1:0] diff_q;
  logic             borrow_q;
  logic             zero_q;

  logic             accept;
  logic             last_bit;

  assign accept   = sub.start && ((state == IDLE) || (state == DONE));
  assign last_bit = (state == RUN) && (cnt == LAST);

  // One full-subtractor slice; d_next already contains the bit being processed this edge.
  always_comb begin
    bit_a   = a_sr[0];
    bit_b   = b_sr[0];
    bit_d   = bit_a ^ bit_b ^ br;
    br_next = (~bit_a & bit_b) | (~(bit_a ^ bit_b) & br);
    d_next  = d_sr >> 1;
    d_next[WIDTH-1] = bit_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      case (state)
        IDLE:    if (accept) state <= RUN;
        RUN:     if (last_bit) state <= DONE;
        DONE:    state <= accept ? RUN : IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sr <= '0;
      b_sr <= '0;
      d_sr <= '0;
      br   <= 1'b0;
      cnt  <= '0;
    end else if (accept) begin
      a_sr <= sub.minuend;
      b_sr <= sub.subtrahend;
      d_sr <= '0;
      br   <= 1'b0;
      cnt  <= '0;
    end else if (state == RUN) begin
      a_sr <= a_sr >> 1;
      b_sr <= b_sr >> 1;
      d_sr <= d_next;
      br   <= br_next;
      cnt  <= cnt + CW'(1);
    end
  end

  // Visible results move only on the final bit, so they stay stable through a following RUN.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      diff_q   <= '0;
      borrow_q <= 1'b0;
      zero_q   <= 1'b0;
    end else if (last_bit) begin
      diff_q   <= d_next;
      borrow_q <= br_next;
      zero_q   <= (d_next == '0);
    end
  end

  assign sub.busy       = (state == RUN);
  assign sub.done       = (state == DONE);
  assign sub.difference = diff_q;
  assign sub.borrow     = borrow_q;
  assign sub.zero       = zero_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed bench for serial_subtractor: an 8-bit and a 1-bit instance sharing clock and reset.
module tb_serial_subtractor;

  logic clk;
  logic rst_n;

  int vectors;
  int miscompares;

  serial_subtractor_if #(.WIDTH(8)) s8 ();
  serial_subtractor_if #(.WIDTH(1)) s1 ();

  serial_subtractor #(.WIDTH(8)) dut8 (.clk(clk), .rst_n(rst_n), .sub(s8));
  serial_subtractor #(.WIDTH(1)) dut1 (.clk(clk), .rst_n(rst_n), .sub(s1));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs are driven and outputs sampled 1ns after each rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start8(input logic [7:0] a, input logic [7:0] b);
    s8.minuend    = a;
    s8.subtrahend = b;
    s8.start      = 1'b1;
    tick();
    s8.start      = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    s8.start = 1'b0; s8.minuend = '0; s8.subtrahend = '0;
    s1.start = 1'b0; s1.minuend = '0; s1.subtrahend = '0;
    tick(); tick();
    vectors++;
    if ({s8.busy, s8.done, s8.borrow, s8.zero} !== 4'b0000) begin
      miscompares++;
      $display("FAIL reset8_flags: got %b, want 0000", {s8.busy, s8.done, s8.borrow, s8.zero});
    end
    vectors++;
    if (s8.difference !== 8'h00) begin
      miscompares++;
      $display("FAIL reset8_diff: got %h, want 00", s8.difference);
    end
    vectors++;
    if ({s1.busy, s1.done, s1.difference, s1.borrow, s1.zero} !== 5'b00000) begin
      miscompares++;
      $display("FAIL reset1_all: got %b, want 00000",
               {s1.busy, s1.done, s1.difference, s1.borrow, s1.zero});
    end
    rst_n = 1'b1;
    tick();
  endtask

  // Runs one 8-bit op, checks busy length, done pulse and results.
  task automatic test_basic(input logic [7:0] a, input logic [7:0] b,
                            input logic [7:0] exp_d, input logic exp_b, input logic exp_z);
    int nb;
    bit overlap;
    nb = 0;
    overlap = 1'b0;
    start8(a, b);
    while (s8.busy && nb < 20) begin
      if (s8.done) overlap = 1'b1;
      nb++;
      tick();
    end
    vectors++;
    if (nb !== 8) begin
      miscompares++;
      $display("FAIL busy_len %0d-%0d: got %0d cycles, want 8", a, b, nb);
    end
    vectors++;
    if (overlap || s8.done !== 1'b1 || s8.busy !== 1'b0) begin
      miscompares++;
      $display("FAIL done_pulse %0d-%0d: done=%b busy=%b overlap=%b, want done=1 busy=0",
               a, b, s8.done, s8.busy, overlap);
    end
    vectors++;
    if (s8.difference !== exp_d || s8.borrow !== exp_b || s8.zero !== exp_z) begin
      miscompares++;
      $display("FAIL result %0d-%0d: got d=%h b=%b z=%b, want d=%h b=%b z=%b",
               a, b, s8.difference, s8.borrow, s8.zero, exp_d, exp_b, exp_z);
    end
    tick();
    vectors++;
    if (s8.done !== 1'b0) begin
      miscompares++;
      $display("FAIL done_drop %0d-%0d: got %b, want 0", a, b, s8.done);
    end
  endtask

  task automatic test_back_to_back();
    int n;
    start8(8'hAA, 8'hAA);
    n = 0;
    while (!s8.done && n < 30) begin n++; tick(); end
    vectors++;
    if (s8.done !== 1'b1 || s8.difference !== 8'h00 || s8.borrow !== 1'b0 || s8.zero !== 1'b1) begin
      miscompares++;
      $display("FAIL b2b_first: got done=%b d=%h b=%b z=%b, want done=1 d=00 b=0 z=1",
               s8.done, s8.difference, s8.borrow, s8.zero);
    end
    // Issued in the DONE cycle, so it is accepted on the edge that leaves DONE.
    start8(8'h00, 8'hFF);
    n = 1;
    while (!s8.done && n < 30) begin n++; tick(); end
    vectors++;
    if (n !== 9) begin
      miscompares++;
      $display("FAIL b2b_spacing: got %0d cycles, want 9", n);
    end
    vectors++;
    if (s8.difference !== 8'h01 || s8.borrow !== 1'b1 || s8.zero !== 1'b0) begin
      miscompares++;
      $display("FAIL b2b_second: got d=%h b=%b z=%b, want d=01 b=1 z=0",
               s8.difference, s8.borrow, s8.zero);
    end
    tick();
  endtask

  task automatic test_ignore_start();
    int ndone;
    logic [7:0] dval;
    ndone = 0;
    dval = 8'hXX;
    start8(8'd10, 8'd4);
    tick(); tick();
    start8(8'd1, 8'd2);
    for (int i = 0; i < 40; i++) begin
      if (s8.done) begin
        if (ndone == 0) dval = s8.difference;
        ndone++;
      end
      tick();
    end
    vectors++;
    if (ndone !== 1) begin
      miscompares++;
      $display("FAIL ignore_done_count: got %0d, want 1", ndone);
    end
    vectors++;
    if (dval !== 8'd6) begin
      miscompares++;
      $display("FAIL ignore_result: got %0d, want 6", dval);
    end
    for (int i = 0; i < 20; i++) begin
      vectors++;
      if (s8.difference !== 8'd6 || s8.busy !== 1'b0 || s8.done !== 1'b0) begin
        miscompares++;
        $display("FAIL hold cycle %0d: got d=%0d busy=%b done=%b, want d=6 busy=0 done=0",
                 i, s8.difference, s8.busy, s8.done);
      end
      tick();
    end
  endtask

  task automatic test_reset_mid();
    int ndone;
    int n;
    start8(8'd200, 8'd1);
    tick(); tick(); tick();
    #2 rst_n = 1'b0;
    #1;
    vectors++;
    if (s8.busy !== 1'b0 || s8.done !== 1'b0 || s8.difference !== 8'h00 ||
        s8.borrow !== 1'b0 || s8.zero !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_mid: got busy=%b done=%b d=%h b=%b z=%b, want all 0",
               s8.busy, s8.done, s8.difference, s8.borrow, s8.zero);
    end
    tick();
    rst_n = 1'b1;
    ndone = 0;
    for (int i = 0; i < 15; i++) begin
      if (s8.done || s8.busy) ndone++;
      tick();
    end
    vectors++;
    if (ndone !== 0) begin
      miscompares++;
      $display("FAIL reset_mid_quiet: got %0d active cycles, want 0", ndone);
    end
    start8(8'd7, 8'd7);
    n = 0;
    while (!s8.done && n < 30) begin n++; tick(); end
    vectors++;
    if (s8.done !== 1'b1 || s8.difference !== 8'h00 || s8.zero !== 1'b1 || s8.borrow !== 1'b0) begin
      miscompares++;
      $display("FAIL after_reset 7-7: got done=%b d=%h z=%b b=%b, want done=1 d=00 z=1 b=0",
               s8.done, s8.difference, s8.zero, s8.borrow);
    end
    tick();
  endtask

  task automatic test_width1();
    logic [3:0] exp_d;
    logic [3:0] exp_b;
    logic [3:0] exp_z;
    logic [1:0] idx;
    exp_d = 4'b0110;
    exp_b = 4'b0010;
    exp_z = 4'b1001;
    for (int k = 0; k < 4; k++) begin
      idx = 2'(k);
      s1.minuend    = idx[1];
      s1.subtrahend = idx[0];
      s1.start      = 1'b1;
      tick();
      s1.start      = 1'b0;
      vectors++;
      if (s1.busy !== 1'b1 || s1.done !== 1'b0) begin
        miscompares++;
        $display("FAIL w1_run %b-%b: got busy=%b done=%b, want 1 0", idx[1], idx[0], s1.busy, s1.done);
      end
      tick();
      vectors++;
      if (s1.done !== 1'b1 || s1.busy !== 1'b0 || s1.difference !== exp_d[idx] ||
          s1.borrow !== exp_b[idx] || s1.zero !== exp_z[idx]) begin
        miscompares++;
        $display("FAIL w1_result %b-%b: got done=%b d=%b b=%b z=%b, want done=1 d=%b b=%b z=%b",
                 idx[1], idx[0], s1.done, s1.difference, s1.borrow, s1.zero,
                 exp_d[idx], exp_b[idx], exp_z[idx]);
      end
      tick();
    end
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    test_reset();
    test_basic(8'd5, 8'd3, 8'h02, 1'b0, 1'b0);
    test_basic(8'd3, 8'd5, 8'hFE, 1'b1, 1'b0);
    test_back_to_back();
    test_ignore_start();
    test_reset_mid();
    test_width1();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
